alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle 8-bit execution unit feeding the register file write port.
// Latches operands on START, runs one of eight ops, then pulses WE/DONE for write-back.
module alu_seq #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         START,
    input  logic [2:0]   OP,
    input  logic [W-1:0] DOA,
    input  logic [W-1:0] DOB,
    output logic [W-1:0] RES,
    output logic         WE,
    output logic         DONE,
    output logic         BUSY,
    output logic         ZF,
    output logic         CF,
    output logic         NF
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpShr = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    // Multiply runs W steps; the counter counts down to zero inclusive.
    localparam logic [2:0] MulSteps = 3'(W - 1);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [W-1:0]   res_q, res_d;
    logic           zf_q, zf_d;
    logic           cf_q, cf_d;
    logic           nf_q, nf_d;

    logic [W-1:0]   exec_res;
    logic           exec_cf;
    logic           exec_last;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            nf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            nf_q    <= nf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        res_d     = res_q;
        zf_d      = zf_q;
        cf_d      = cf_q;
        nf_d      = nf_q;
        exec_res  = '0;
        exec_cf   = 1'b0;
        exec_last = 1'b0;

        // Shift-add step: add A into the upper half when the multiplier LSB is set, shift right.
        mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, prod_q[W-1:1]};

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StExec;
                    op_d    = OP;
                    a_d     = DOA;
                    b_d     = DOB;
                    acc_d   = DOA;
                    cnt_d   = (OP == OpMul) ? MulSteps : DOB[2:0];
                    prod_d  = {{W{1'b0}}, DOB};
                end
            end
            StExec: begin
                unique case (op_q)
                    OpAdd: begin
                        {exec_cf, exec_res} = {1'b0, a_q} + {1'b0, b_q};
                        exec_last = 1'b1;
                    end
                    OpSub: begin
                        exec_res  = a_q - b_q;
                        exec_cf   = (a_q < b_q);
                        exec_last = 1'b1;
                    end
                    OpAnd: begin
                        exec_res  = a_q & b_q;
                        exec_last = 1'b1;
                    end
                    OpOr: begin
                        exec_res  = a_q | b_q;
                        exec_last = 1'b1;
                    end
                    OpXor: begin
                        exec_res  = a_q ^ b_q;
                        exec_last = 1'b1;
                    end
                    OpShl: begin
                        if (cnt_q != 3'd0) begin
                            {exec_cf, exec_res} = {acc_q, 1'b0};
                            acc_d = exec_res;
                            cnt_d = cnt_q - 3'd1;
                        end else begin
                            exec_res = acc_q;
                        end
                        exec_last = (cnt_q <= 3'd1);
                    end
                    OpShr: begin
                        if (cnt_q != 3'd0) begin
                            {exec_res, exec_cf} = {1'b0, acc_q};
                            acc_d = exec_res;
                            cnt_d = cnt_q - 3'd1;
                        end else begin
                            exec_res = acc_q;
                        end
                        exec_last = (cnt_q <= 3'd1);
                    end
                    OpMul: begin
                        prod_d    = mul_next;
                        exec_res  = mul_next[W-1:0];
                        exec_cf   = |mul_next[2*W-1:W];
                        cnt_d     = cnt_q - 3'd1;
                        exec_last = (cnt_q == 3'd0);
                    end
                endcase
                // Result and flags load only on the edge entering WB, so they hold through EXEC.
                if (exec_last) begin
                    state_d = StWb;
                    res_d   = exec_res;
                    cf_d    = exec_cf;
                    zf_d    = (exec_res == '0);
                    nf_d    = exec_res[W-1];
                end
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign RES  = res_q;
    assign ZF   = zf_q;
    assign CF   = cf_q;
    assign NF   = nf_q;
    assign WE   = (state_q == StWb);
    assign DONE = (state_q == StWb);
    assign BUSY = (state_q != StIdle);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, randomized ops against a
// behavioural model, protocol, abort-by-reset and back-to-back throughput.
module tb_alu_seq;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpShr = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    logic       clk;
    logic       rst_n;
    logic       START;
    logic [2:0] OP;
    logic [7:0] DOA;
    logic [7:0] DOB;
    logic [7:0] RES;
    logic       WE;
    logic       DONE;
    logic       BUSY;
    logic       ZF;
    logic       CF;
    logic       NF;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       z;
        logic       c;
        logic       n;
        logic [3:0] lat;
    } vec_t;

    alu_seq #(.W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .START(START),
        .OP   (OP),
        .DOA  (DOA),
        .DOB  (DOB),
        .RES  (RES),
        .WE   (WE),
        .DONE (DONE),
        .BUSY (BUSY),
        .ZF   (ZF),
        .CF   (CF),
        .NF   (NF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Reference: result, carry and latency (edges from acceptance to end of WB) from the op rules.
    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output int lat);
        int ia, ib, n, p;
        ia  = int'(a);
        ib  = int'(b);
        n   = int'(b[2:0]);
        p   = 0;
        c   = 1'b0;
        lat = 2;
        case (op)
            OpAdd: begin p = ia + ib; c = (p > 255); end
            OpSub: begin p = ia - ib; c = (ia < ib); end
            OpAnd: p = ia & ib;
            OpOr:  p = ia | ib;
            OpXor: p = ia ^ ib;
            OpShl: begin
                p   = ia << n;
                c   = (n != 0) && (p[8] == 1'b1);
                lat = (n == 0) ? 2 : n + 1;
            end
            OpShr: begin
                p   = ia >> n;
                c   = (n != 0) && (((ia >> (n - 1)) & 1) == 1);
                lat = (n == 0) ? 2 : n + 1;
            end
            default: begin p = ia * ib; c = (p > 255); lat = 9; end
        endcase
        r = p[7:0];
    endfunction

    // Issues one op and records what the DUT did; sampling is on negedges, so the k-th
    // negedge after the accepting edge shows the state after edge t0+k-1.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [7:0] res, output logic z,
                          output logic c, output logic n, output int we_cnt,
                          output logic busy_ok, output logic done_ok,
                          output logic stable_ok, output logic hold_ok);
        logic [10:0] pre;
        lat = 0; we_cnt = 0; res = '0; z = 1'b0; c = 1'b0; n = 1'b0;
        busy_ok = 1'b1; done_ok = 1'b1; stable_ok = 1'b1; hold_ok = 1'b0;
        @(negedge clk);
        pre   = {RES, ZF, CF, NF};
        START = 1'b1; OP = op; DOA = a; DOB = b;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                START = 1'b0;
                OP    = 3'($urandom);
                DOA   = 8'($urandom);
                DOB   = 8'($urandom);
            end
            if (DONE !== WE) done_ok = 1'b0;
            if (WE === 1'b1) begin
                if (we_cnt == 0) begin
                    lat = k;
                    {res, z, c, n} = {RES, ZF, CF, NF};
                end
                we_cnt++;
                if (BUSY !== 1'b1) busy_ok = 1'b0;
            end else if (we_cnt > 0) begin
                if (BUSY !== 1'b0) busy_ok = 1'b0;
                hold_ok = ({RES, ZF, CF, NF} === {res, z, c, n});
                break;
            end else begin
                if (BUSY !== 1'b1) busy_ok = 1'b0;
                if ({RES, ZF, CF, NF} !== pre) stable_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic we_seen;
        we_seen = 1'b0;
        rst_n = 1'b0; START = 1'b1; OP = OpMul; DOA = 8'hAA; DOB = 8'h55;
        repeat (2) begin
            @(negedge clk);
            if (WE === 1'b1) we_seen = 1'b1;
        end
        checks++;
        if ({RES, ZF, CF, NF, WE, DONE, BUSY} !== 14'h0) begin
            failures++;
            $display("FAIL reset outputs: got %h want 0000", {RES, ZF, CF, NF, WE, DONE, BUSY});
        end
        checks++;
        if (we_seen !== 1'b0) begin
            failures++;
            $display("FAIL reset we_pulse: got %b want 0", we_seen);
        end
        rst_n = 1'b1; START = 1'b0;
        @(negedge clk);
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset start_dropped: BUSY got %b want 0", BUSY);
        end
    endtask

    task automatic test_arith();
        vec_t v [4];
        int lat, wec;
        logic [7:0] r;
        logic z, c, n, bo, dn, st, ho;
        v[0] = '{OpAdd, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 4'd2};
        v[1] = '{OpSub, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2};
        v[2] = '{OpSub, 8'h03, 8'h04, 8'hFF, 1'b0, 1'b1, 1'b1, 4'd2};
        v[3] = '{OpXor, 8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, r, z, c, n, wec, bo, dn, st, ho);
            checks++;
            if (lat != int'(v[i].lat)) begin
                failures++;
                $display("FAIL arith[%0d] latency: got %0d want %0d", i, lat, v[i].lat);
            end
            checks++;
            if ({r, z, c, n} !== {v[i].r, v[i].z, v[i].c, v[i].n}) begin
                failures++;
                $display("FAIL arith[%0d] result: got %h z%b c%b n%b want %h z%b c%b n%b",
                         i, r, z, c, n, v[i].r, v[i].z, v[i].c, v[i].n);
            end
            checks++;
            if ({wec == 1, bo, dn, st, ho} !== 5'b11111) begin
                failures++;
                $display("FAIL arith[%0d] handshake(we1,busy,done,stable,hold): got %b want 11111",
                         i, {wec == 1, bo, dn, st, ho});
            end
        end
    endtask

    task automatic test_shifts();
        vec_t v [4];
        int lat, wec;
        logic [7:0] r;
        logic z, c, n, bo, dn, st, ho;
        v[0] = '{OpShl, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 4'd4};
        v[1] = '{OpShr, 8'h81, 8'h01, 8'h40, 1'b0, 1'b1, 1'b0, 4'd2};
        v[2] = '{OpShr, 8'h9C, 8'h00, 8'h9C, 1'b0, 1'b0, 1'b1, 4'd2};
        v[3] = '{OpShl, 8'h5A, 8'hF8, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd2};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, r, z, c, n, wec, bo, dn, st, ho);
            checks++;
            if (lat != int'(v[i].lat)) begin
                failures++;
                $display("FAIL shift[%0d] latency: got %0d want %0d", i, lat, v[i].lat);
            end
            checks++;
            if ({r, z, c, n} !== {v[i].r, v[i].z, v[i].c, v[i].n}) begin
                failures++;
                $display("FAIL shift[%0d] result: got %h z%b c%b n%b want %h z%b c%b n%b",
                         i, r, z, c, n, v[i].r, v[i].z, v[i].c, v[i].n);
            end
            checks++;
            if ({wec == 1, bo, dn, st, ho} !== 5'b11111) begin
                failures++;
                $display("FAIL shift[%0d] handshake(we1,busy,done,stable,hold): got %b want 11111",
                         i, {wec == 1, bo, dn, st, ho});
            end
        end
    endtask

    task automatic test_mul();
        vec_t v [2];
        int lat, wec;
        logic [7:0] r;
        logic z, c, n, bo, dn, st, ho;
        v[0] = '{OpMul, 8'h10, 8'h11, 8'h10, 1'b0, 1'b1, 1'b0, 4'd9};
        v[1] = '{OpMul, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b1, 4'd9};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, r, z, c, n, wec, bo, dn, st, ho);
            checks++;
            if (lat != int'(v[i].lat)) begin
                failures++;
                $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, v[i].lat);
            end
            checks++;
            if ({r, z, c, n} !== {v[i].r, v[i].z, v[i].c, v[i].n}) begin
                failures++;
                $display("FAIL mul[%0d] result: got %h z%b c%b n%b want %h z%b c%b n%b",
                         i, r, z, c, n, v[i].r, v[i].z, v[i].c, v[i].n);
            end
            checks++;
            if ({wec == 1, bo, dn, st, ho} !== 5'b11111) begin
                failures++;
                $display("FAIL mul[%0d] handshake(we1,busy,done,stable,hold): got %b want 11111",
                         i, {wec == 1, bo, dn, st, ho});
            end
        end
    endtask

    task automatic test_random();
        int lat, wec, elat;
        logic [7:0] r, er, a, b;
        logic z, c, n, ec, bo, dn, st, ho;
        logic [2:0] op;
        for (int i = 0; i < 48; i++) begin
            op = 3'(i % 8);
            a  = 8'($urandom);
            b  = 8'($urandom);
            model(op, a, b, er, ec, elat);
            run_op(op, a, b, lat, r, z, c, n, wec, bo, dn, st, ho);
            checks++;
            if (lat != elat) begin
                failures++;
                $display("FAIL rand[%0d] op%0d a=%h b=%h latency: got %0d want %0d",
                         i, op, a, b, lat, elat);
            end
            checks++;
            if ({r, z, c, n} !== {er, er == 8'h00, ec, er[7]}) begin
                failures++;
                $display("FAIL rand[%0d] op%0d a=%h b=%h result: got %h z%b c%b n%b want %h c%b",
                         i, op, a, b, r, z, c, n, er, ec);
            end
            checks++;
            if ({wec == 1, bo, dn, st, ho} !== 5'b11111) begin
                failures++;
                $display("FAIL rand[%0d] handshake(we1,busy,done,stable,hold): got %b want 11111",
                         i, {wec == 1, bo, dn, st, ho});
            end
        end
    endtask

    // A START pulse with new operands mid-multiply must be ignored entirely.
    task automatic test_protocol();
        int lat, wec;
        logic [7:0] r;
        logic z, c, n;
        lat = 0; wec = 0; r = '0; z = 1'b0; c = 1'b0; n = 1'b0;
        @(negedge clk);
        START = 1'b1; OP = OpMul; DOA = 8'h0D; DOB = 8'h0B;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (WE === 1'b1) begin
                if (wec == 0) begin
                    lat = k;
                    {r, z, c, n} = {RES, ZF, CF, NF};
                end
                wec++;
            end
            if (k == 1) begin START = 1'b0; DOA = 8'hFF; DOB = 8'hFF; OP = OpAdd; end
            if (k == 3) begin START = 1'b1; DOA = 8'h77; DOB = 8'h33; OP = OpSub; end
            if (k == 4) begin START = 1'b0; DOA = 8'h01; DOB = 8'h02; end
        end
        checks++;
        if (lat != 9) begin
            failures++;
            $display("FAIL protocol latency: got %0d want 9", lat);
        end
        checks++;
        if ({r, z, c, n} !== {8'h8F, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL protocol result: got %h z%b c%b n%b want 8f z0 c0 n1", r, z, c, n);
        end
        checks++;
        if (wec != 1) begin
            failures++;
            $display("FAIL protocol we_count: got %0d want 1", wec);
        end
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL protocol idle_after: BUSY got %b want 0", BUSY);
        end
    endtask

    task automatic test_abort();
        int lat, wec;
        logic [7:0] r;
        logic z, c, n, bo, dn, st, ho, we_seen;
        run_op(OpAdd, 8'h40, 8'h41, lat, r, z, c, n, wec, bo, dn, st, ho);
        checks++;
        if ({r, z, c, n} !== {8'h81, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL abort setup result: got %h z%b c%b n%b want 81 z0 c0 n1", r, z, c, n);
        end
        we_seen = 1'b0;
        @(negedge clk);
        START = 1'b1; OP = OpMul; DOA = 8'hFF; DOB = 8'hFF;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) START = 1'b0;
            if (WE === 1'b1) we_seen = 1'b1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({RES, ZF, CF, NF, WE, DONE, BUSY} !== 14'h0) begin
            failures++;
            $display("FAIL abort outputs: got %h want 0000", {RES, ZF, CF, NF, WE, DONE, BUSY});
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (WE === 1'b1) we_seen = 1'b1;
        end
        checks++;
        if (we_seen !== 1'b0) begin
            failures++;
            $display("FAIL abort we_pulse: got %b want 0", we_seen);
        end
        run_op(OpAdd, 8'h01, 8'h02, lat, r, z, c, n, wec, bo, dn, st, ho);
        checks++;
        if (lat != 2 || {r, z, c, n} !== {8'h03, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort restart: got lat=%0d res=%h z%b c%b n%b want lat=2 res=03 z0c0n0",
                     lat, r, z, c, n);
        end
    endtask

    // START held high: each op starts on the first idle edge using operands present then.
    task automatic test_back_to_back();
        vec_t v [3];
        int idx, exp_cyc, cyc;
        v[0] = '{OpAdd, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, 4'd2};
        v[1] = '{OpShl, 8'h03, 8'h02, 8'h0C, 1'b0, 1'b0, 1'b0, 4'd3};
        v[2] = '{OpMul, 8'h07, 8'h06, 8'h2A, 1'b0, 1'b0, 1'b0, 4'd9};
        idx = 0;
        exp_cyc = int'(v[0].lat);
        cyc = 0;
        @(negedge clk);
        START = 1'b1; OP = v[0].op; DOA = v[0].a; DOB = v[0].b;
        while (idx < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (WE === 1'b1) begin
                checks++;
                if (cyc != exp_cyc || RES !== v[idx].r) begin
                    failures++;
                    $display("FAIL b2b[%0d]: got cycle=%0d res=%h want cycle=%0d res=%h",
                             idx, cyc, RES, exp_cyc, v[idx].r);
                end
                idx++;
                if (idx < 3) begin
                    OP = v[idx].op; DOA = v[idx].a; DOB = v[idx].b;
                    exp_cyc = cyc + int'(v[idx].lat) + 1;
                end else begin
                    START = 1'b0;
                end
            end
        end
        checks++;
        if (idx != 3) begin
            failures++;
            $display("FAIL b2b completions: got %0d want 3", idx);
        end
        START = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL b2b idle_after: BUSY got %b want 0", BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shifts();
        test_mul();
        test_random();
        test_protocol();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
